// File: rtl/gate_unit_arbiter_pkg.sv
// Shared opcode and FSM state encodings for the gate-unit arbiter.
// Pure definitions, no logic; latency and backpressure not applicable.
// Imported by the arbiter top and the gate ALU.
package gate_unit_arbiter_pkg;

    // Gate opcodes, bitwise over the operand width
    localparam logic [1:0] OP_INV  = 2'b00;
    localparam logic [1:0] OP_NAND = 2'b01;
    localparam logic [1:0] OP_NOR  = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/gate_unit_arbiter_gate_alu.sv
// Vector gate unit: INV / NAND / NOR per bit, selected by a 2-bit opcode.
// Purely combinational, zero latency.
// No handshake; the reserved opcode yields zero data and raises err.
module gate_alu
    import gate_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    logic [WIDTH-1:0] inv_y;
    logic [WIDTH-1:0] nand_y;
    logic [WIDTH-1:0] nor_y;

    // One primitive of each kind per bit; the opcode only picks which result leaves
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        not  u_not  (inv_y[i],  a[i]);
        nand u_nand (nand_y[i], a[i], b[i]);
        nor  u_nor  (nor_y[i],  a[i], b[i]);
    end

    // 4:1 result select; the reserved code returns zero and flags an error
    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_INV:  y = inv_y;
            OP_NAND: y = nand_y;
            OP_NOR:  y = nor_y;
            OP_RSV: begin
                y   = '0;
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate ALU among NREQ requesters, one op in flight.
// Latency: request sampled at edge T, gnt during the following cycle, result registered one edge later.
// Backpressure: result held stable while rsp_ready is low; requests are ignored until it is taken.
module gate_unit_arbiter
    import gate_unit_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] a,
    input  logic [WIDTH*NREQ-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_err,
    output logic [15:0]           done_cnt
);

    logic [1:0]       state;
    logic [IDW-1:0]   ptr;
    logic [1:0]       lat_op;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [IDW-1:0]   lat_id;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    // Priority search starting at ptr and wrapping; walking backwards lets the
    // closest set bit to ptr overwrite any farther candidate
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // Winner's operand slices, captured only on the grant edge
    always_comb begin
        sel_op = op[2*int'(win_idx) +: 2];
        sel_a  = a[WIDTH*int'(win_idx) +: WIDTH];
        sel_b  = b[WIDTH*int'(win_idx) +: WIDTH];
    end

    gate_alu #(
        .WIDTH (WIDTH)
    ) u_gate_alu (
        .op  (lat_op),
        .a   (lat_a),
        .b   (lat_b),
        .y   (alu_y),
        .err (alu_err)
    );

    // FSM: grant and latch in IDLE, register the ALU result in EVAL, hand it off in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_id    <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            done_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_found) begin
                        lat_op <= sel_op;
                        lat_a  <= sel_a;
                        lat_b  <= sel_b;
                        lat_id <= win_idx;
                        gnt    <= NREQ'(1) << win_idx;
                        busy   <= 1'b1;
                        state  <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    gnt       <= '0;
                    rsp_data  <= alu_y;
                    rsp_err   <= alu_err;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + 16'd1;
                        ptr       <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    busy      <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Randomized bench for gate_unit_arbiter with a behavioural round-robin/gate model.
// Each scenario task drives its stimulus and compares against the model inline.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_gate_unit_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 3;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] a;
    logic [WIDTH*NREQ-1:0] b;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_err;
    logic [15:0]           done_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: next round-robin start index and expected completion count
    int          rr      = 0;
    logic [15:0] exp_cnt = '0;

    gate_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++)
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] model_gate(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        case (o)
            2'd0:    return ~x;
            2'd1:    return ~(x & y);
            2'd2:    return ~(x | y);
            default: return '0;
        endcase
    endfunction

    // Present one request set, wait for the grant, drop req and scramble operands,
    // then wait for the response; returns what was observed
    task automatic run_op(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                          input logic [WIDTH*NREQ-1:0] av, input logic [WIDTH*NREQ-1:0] bv,
                          output logic [NREQ-1:0] g, output int gw, output logic [IDW-1:0] id,
                          output logic [WIDTH-1:0] d, output logic e, output bit ok);
        int k;
        @(negedge clk);
        req = r; op = o; a = av; b = bv;
        gw = 0; ok = 0; id = '0; d = '0; e = 1'b0;
        do begin @(posedge clk); #1; gw++; end while (gnt == '0 && gw < 20);
        g = gnt;
        if (g == '0) return;
        @(negedge clk);
        req = '0; op = 8'($urandom()); a = $urandom(); b = $urandom();
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!rsp_valid && k < 20);
        if (!rsp_valid) return;
        id = rsp_id; d = rsp_data; e = rsp_err; ok = 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; req = '0; rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rr = 0; exp_cnt = '0;
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        int k;
        rst = 1'b1; req = '0; op = '0; a = '0; b = '0; rsp_ready = 1'b1;
        #1;
        n_cmp++; if ({gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err, done_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_init: outputs=%h required all zero",
                {gnt, busy, rsp_valid, rsp_id, rsp_data, rsp_err, done_cnt}); end
        @(negedge clk); rst = 1'b0;
        // one completed op so done_cnt is non-zero, then park a second op in RESP
        run_op(4'b0001, 8'h00, 32'h0000_0033, 32'h0, g, gw, id, d, e, ok);
        @(posedge clk); #1;
        run_op(4'b0010, 8'h04, 32'h0, 32'h0, g, gw, id, d, e, ok);
        rsp_ready = 1'b0;
        n_cmp++; if (!ok || d !== 8'hFF) begin
            n_fail++; $display("FAIL reset_pre_op: ok=%0d data=%h required ok=1 data=ff", ok, d); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (gnt !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_ctl: gnt=%b busy=%b vld=%b required 0", gnt, busy, rsp_valid); end
        n_cmp++; if (rsp_id !== '0 || rsp_data !== '0 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_rsp: id=%0d data=%h err=%b required 0", rsp_id, rsp_data, rsp_err); end
        n_cmp++; if (done_cnt !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_cnt: done_cnt=%0d required 0", done_cnt); end
        @(negedge clk);
        rst = 1'b0; rsp_ready = 1'b1; rr = 0; exp_cnt = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_cmp++; if (gnt !== '0 || rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL reset_discard: gnt=%b vld=%b required 0", gnt, rsp_valid); end
        end
        @(negedge clk); req = 4'b0001;
        @(posedge clk); #1;
        n_cmp++; if (gnt !== 4'b0001) begin
            n_fail++; $display("FAIL reset_first_gnt: gnt=%b required 0001", gnt); end
        @(negedge clk); req = '0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!rsp_valid && k < 20);
        @(posedge clk); #1;
        exp_cnt++; rr = 1;
        n_cmp++; if (done_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL reset_first_cnt: done_cnt=%0d required %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_single_op();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        logic [2*NREQ-1:0] o; logic [WIDTH*NREQ-1:0] av, bv;
        o = 8'($urandom()); av = $urandom(); bv = $urandom();
        o[5:4] = 2'b01; av[23:16] = 8'hF0; bv[23:16] = 8'h3C;
        run_op(4'b0100, o, av, bv, g, gw, id, d, e, ok);
        n_cmp++; if (!ok || g !== 4'b0100 || gw != 1) begin
            n_fail++; $display("FAIL single_gnt: ok=%0d gnt=%b wait=%0d required gnt=0100 wait=1", ok, g, gw); end
        n_cmp++; if (d !== 8'hCF || id !== 3'd2 || e !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: data=%h id=%0d err=%b required cf/2/0", d, id, e); end
        @(posedge clk); #1;
        exp_cnt++; rr = 3;
        n_cmp++; if (done_cnt !== exp_cnt || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: cnt=%0d vld=%b required %0d/0", done_cnt, rsp_valid, exp_cnt); end
    endtask

    task automatic test_ops();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        logic [2*NREQ-1:0] o; logic [WIDTH*NREQ-1:0] av, bv;
        logic [1:0] codes [3]; logic [7:0] as [3]; logic [7:0] bs [3]; logic [7:0] want [3];
        int w;
        codes = '{2'b00, 2'b10, 2'b11};
        as    = '{8'hA5, 8'h0F, 8'h77};
        bs    = '{8'h00, 8'h30, 8'h11};
        want  = '{8'h5A, 8'hC0, 8'h00};
        for (int t = 0; t < 3; t++) begin
            w = int'($urandom_range(0, NREQ - 1));
            o = 8'($urandom()); av = $urandom(); bv = $urandom();
            o[2*w +: 2] = codes[t]; av[8*w +: 8] = as[t]; bv[8*w +: 8] = bs[t];
            run_op(4'(1 << w), o, av, bv, g, gw, id, d, e, ok);
            n_cmp++; if (!ok || d !== want[t] || e !== (codes[t] == 2'b11) || id !== IDW'(w)) begin
                n_fail++; $display("FAIL ops_%0d: ok=%0d data=%h err=%b id=%0d required %h/%b/%0d",
                    t, ok, d, e, id, want[t], codes[t] == 2'b11, w); end
            @(posedge clk); #1;
            exp_cnt++; rr = (w + 1) % NREQ;
        end
        n_cmp++; if (done_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL ops_cnt: done_cnt=%0d required %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        logic [NREQ-1:0] r; logic [2*NREQ-1:0] o; logic [WIDTH*NREQ-1:0] av, bv;
        int w;
        for (int t = 0; t < 30; t++) begin
            r = 4'($urandom_range(1, 15)); o = 8'($urandom()); av = $urandom(); bv = $urandom();
            w = pick(r, rr);
            run_op(r, o, av, bv, g, gw, id, d, e, ok);
            n_cmp++; if (!ok || g !== 4'(1 << w) || gw != 1 || id !== IDW'(w)) begin
                n_fail++; $display("FAIL rand_gnt_%0d: ok=%0d gnt=%b wait=%0d id=%0d required winner %0d",
                    t, ok, g, gw, id, w); end
            n_cmp++; if (d !== model_gate(o[2*w +: 2], av[8*w +: 8], bv[8*w +: 8]) ||
                         e !== (o[2*w +: 2] == 2'b11)) begin
                n_fail++; $display("FAIL rand_rsp_%0d: data=%h err=%b required %h/%b", t, d, e,
                    model_gate(o[2*w +: 2], av[8*w +: 8], bv[8*w +: 8]), o[2*w +: 2] == 2'b11); end
            @(posedge clk); #1;
            exp_cnt++; rr = (w + 1) % NREQ;
            n_cmp++; if (done_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL rand_cnt_%0d: done_cnt=%0d required %0d", t, done_cnt, exp_cnt); end
        end
    endtask

    task automatic test_fairness();
        int ng, last, cur, w;
        apply_reset();
        @(negedge clk);
        op = 8'($urandom()); a = $urandom(); b = $urandom(); req = 4'hF; rsp_ready = 1'b1;
        ng = 0; last = 0; cur = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk); #1;
            if (gnt != '0) begin
                w = rr;
                n_cmp++; if (gnt !== 4'(1 << w) || (ng > 0 && c - last != 3)) begin
                    n_fail++; $display("FAIL fair_gnt_%0d: gnt=%b gap=%0d required gnt index %0d gap 3",
                        ng, gnt, c - last, w); end
                last = c; cur = w; rr = (w + 1) % NREQ; exp_cnt++; ng++;
            end
            if (rsp_valid) begin
                n_cmp++; if (rsp_id !== IDW'(cur)) begin
                    n_fail++; $display("FAIL fair_id: rsp_id=%0d required %0d", rsp_id, cur); end
            end
            @(negedge clk);
            req = (c >= 13) ? 4'h0 : ~gnt;
        end
        n_cmp++; if (ng != 5 || done_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL fair_total: grants=%0d cnt=%0d required 5/%0d", ng, done_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        logic [2*NREQ-1:0] o; logic [WIDTH*NREQ-1:0] av, bv;
        int i, j, k;
        i = int'($urandom_range(0, NREQ - 1)); j = (i + 1 + int'($urandom_range(0, NREQ - 2))) % NREQ;
        o = 8'($urandom()); av = $urandom(); bv = $urandom();
        o[2*i +: 2] = 2'b01;
        rsp_ready = 1'b0;
        run_op(4'(1 << i), o, av, bv, g, gw, id, d, e, ok);
        n_cmp++; if (!ok || d !== model_gate(2'b01, av[8*i +: 8], bv[8*i +: 8]) || id !== IDW'(i)) begin
            n_fail++; $display("FAIL bp_rsp: ok=%0d data=%h id=%0d required %h/%0d", ok, d, id,
                model_gate(2'b01, av[8*i +: 8], bv[8*i +: 8]), i); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); req = 4'(1 << j);
            @(posedge clk); #1;
            n_cmp++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_data, rsp_err} !== {id, d, e} ||
                         busy !== 1'b1 || gnt !== '0) begin
                n_fail++; $display("FAIL bp_hold_%0d: vld=%b id=%0d data=%h err=%b busy=%b gnt=%b required held",
                    c, rsp_valid, rsp_id, rsp_data, rsp_err, busy, gnt); end
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        exp_cnt++; rr = (i + 1) % NREQ;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL bp_accept: vld=%b busy=%b cnt=%0d required 0/0/%0d",
                rsp_valid, busy, done_cnt, exp_cnt); end
        @(posedge clk); #1;
        n_cmp++; if (gnt !== 4'(1 << j)) begin
            n_fail++; $display("FAIL bp_next_gnt: gnt=%b required index %0d", gnt, j); end
        @(negedge clk); req = '0;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!rsp_valid && k < 20);
        @(posedge clk); #1;
        exp_cnt++; rr = (j + 1) % NREQ;
        n_cmp++; if (done_cnt !== exp_cnt) begin
            n_fail++; $display("FAIL bp_cnt: done_cnt=%0d required %0d", done_cnt, exp_cnt); end
    endtask

    task automatic test_counter_wrap();
        logic [NREQ-1:0] g; int gw; logic [IDW-1:0] id; logic [WIDTH-1:0] d; logic e; bit ok;
        logic [NREQ-1:0] r; int w;
        @(negedge clk);
        force dut.done_cnt = 16'hFFFE;
        #1;
        release dut.done_cnt;
        exp_cnt = 16'hFFFE;
        for (int t = 0; t < 2; t++) begin
            r = 4'($urandom_range(1, 15)); w = pick(r, rr);
            run_op(r, 8'($urandom()), $urandom(), $urandom(), g, gw, id, d, e, ok);
            @(posedge clk); #1;
            exp_cnt++; rr = (w + 1) % NREQ;
            n_cmp++; if (!ok || done_cnt !== exp_cnt) begin
                n_fail++; $display("FAIL wrap_%0d: ok=%0d done_cnt=%h required %h", t, ok, done_cnt, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_ops();
        test_random();
        test_fairness();
        test_backpressure();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
